// File: rtl/glitch_pkg.sv
// Shared constants for the glitch pulse generator: FSM encoding and config register selects.
package glitch_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_DELAY = 3'd2;
    localparam logic [2:0] ST_PULSE = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [1:0] SEL_DELAY = 2'd0;
    localparam logic [1:0] SEL_WIDTH = 2'd1;
    localparam logic [1:0] SEL_GAP   = 2'd2;
    localparam logic [1:0] SEL_COUNT = 2'd3;

    // Busy covers every state between arming and the end of the pulse train.
    function automatic logic is_busy(input logic [ST_W-1:0] st);
        return (st == ST_ARMED) || (st == ST_DELAY) || (st == ST_PULSE) || (st == ST_GAP);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous level followed by a registered rising-edge detector.
module edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // STAGES must be at least 2 for metastability settling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/glitch_pulse_gen.sv
// Armed, trigger-started glitch pulse train generator: delay, then count pulses of width separated by gap.
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             glitch_clk,
    input  logic             glitch_reset,
    input  logic             trigger,
    input  logic             arm,
    input  logic             abort,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             glitch_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    logic [ST_W-1:0]  state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] pls_q, pls_n;
    logic [CNT_W-1:0] cfg_delay, cfg_width, cfg_gap, cfg_count;
    logic             trig_rise;
    logic             cfg_open;
    logic             done_n;

    // Zero width/gap/count are treated as one.
    function automatic logic [CNT_W-1:0] max1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_trig_sync (
        .clk  (glitch_clk),
        .rst  (glitch_reset),
        .din  (trigger),
        .rise (trig_rise)
    );

    assign cfg_open = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Configuration registers, writable only while no event is in flight.
    always_ff @(posedge glitch_clk or posedge glitch_reset) begin
        if (glitch_reset) begin
            cfg_delay <= '0;
            cfg_width <= CNT_W'(1);
            cfg_gap   <= CNT_W'(1);
            cfg_count <= CNT_W'(1);
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~cfg_open;
            if (cfg_we && cfg_open) begin
                case (cfg_sel)
                    SEL_DELAY: cfg_delay <= cfg_data;
                    SEL_WIDTH: cfg_width <= cfg_data;
                    SEL_GAP:   cfg_gap   <= cfg_data;
                    default:   cfg_count <= cfg_data;
                endcase
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge glitch_clk or posedge glitch_reset) begin
        if (glitch_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pls_q      <= '0;
            glitch_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            pls_q      <= pls_n;
            glitch_out <= (state_n == ST_PULSE);
            busy       <= is_busy(state_n);
            done       <= done_n;
        end
    end

    // Next-state logic; counters reload on every state entry and exit at one.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        pls_n   = pls_q;
        done_n  = 1'b0;

        if (abort && is_busy(state_q)) begin
            state_n = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) state_n = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_rise) begin
                        pls_n = max1(cfg_count);
                        if (cfg_delay == '0) begin
                            state_n = ST_PULSE;
                            cnt_n   = max1(cfg_width);
                        end else begin
                            state_n = ST_DELAY;
                            cnt_n   = cfg_delay;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_n = ST_PULSE;
                        cnt_n   = max1(cfg_width);
                    end else begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == CNT_W'(1)) begin
                        if (pls_q == CNT_W'(1)) begin
                            state_n = ST_DONE;
                        end else begin
                            state_n = ST_GAP;
                            cnt_n   = max1(cfg_gap);
                            pls_n   = pls_q - CNT_W'(1);
                        end
                    end else begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_n = ST_PULSE;
                        cnt_n   = max1(cfg_width);
                    end else begin
                        cnt_n = cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed self-checking bench for glitch_pulse_gen; per-edge output histories are compared as bit vectors.
module tb_glitch_pulse_gen;
    import glitch_pkg::*;

    logic        glitch_clk = 1'b0;
    logic        glitch_reset;
    logic        trigger;
    logic        arm;
    logic        abort;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic        glitch_out;
    logic        busy;
    logic        done;
    logic        cfg_err;

    logic [63:0] out_v, done_v, busy_v, err_v;
    int          n_checks = 0;
    int          n_pass   = 0;

    localparam logic [63:0] TRAIN_OUT  = 64'h0000_0000_78F1_E000;
    localparam logic [63:0] TRAIN_DONE = 64'h0000_0001_0000_0000;

    glitch_pulse_gen #(
        .CNT_W       (16),
        .SYNC_STAGES (2)
    ) dut (
        .glitch_clk   (glitch_clk),
        .glitch_reset (glitch_reset),
        .trigger      (trigger),
        .arm          (arm),
        .abort        (abort),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .glitch_out   (glitch_out),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 glitch_clk = ~glitch_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge glitch_clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Bit k of each history is the output right after edge k; trigger is first sampled high at edge 0.
    task automatic run_capture(input int n, input int abort_at, input int cfg_at,
                               input logic [1:0] sel, input logic [15:0] data,
                               input int drop_lo, input int drop_hi);
        out_v  = '0;
        done_v = '0;
        busy_v = '0;
        err_v  = '0;
        for (int k = 0; k < n; k++) begin
            trigger  = !(k >= drop_lo && k < drop_hi);
            abort    = (k == abort_at);
            cfg_we   = (k == cfg_at);
            cfg_sel  = sel;
            cfg_data = data;
            tick();
            out_v[k]  = glitch_out;
            done_v[k] = done;
            busy_v[k] = busy;
            err_v[k]  = cfg_err;
        end
        trigger = 1'b0;
        abort   = 1'b0;
        cfg_we  = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        glitch_reset = 1'b1;
        trigger      = 1'b0;
        arm          = 1'b0;
        abort        = 1'b0;
        cfg_we       = 1'b0;
        cfg_sel      = 2'd0;
        cfg_data     = 16'd0;
        repeat (3) tick();
        check("rst_glitch_out", 64'(glitch_out), 64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_done",       64'(done),       64'd0);
        check("rst_cfg_err",    64'(cfg_err),    64'd0);
        glitch_reset = 1'b0;
        repeat (2) tick();

        arm_pulse();
        run_capture(40, -1, -1, SEL_DELAY, 16'd0, -1, -1);
        check("dflt_out",  out_v,  64'h8);
        check("dflt_done", done_v, 64'h20);

        cfg_write(SEL_DELAY, 16'd10);
        check("cfg_idle_no_err", 64'(cfg_err), 64'd0);
        cfg_write(SEL_WIDTH, 16'd4);
        cfg_write(SEL_GAP,   16'd3);
        cfg_write(SEL_COUNT, 16'd3);
        tick();

        arm_pulse();
        run_capture(40, -1, -1, SEL_DELAY, 16'd0, -1, -1);
        check("train_out",  out_v,  TRAIN_OUT);
        check("train_done", done_v, TRAIN_DONE);
        check("train_busy", busy_v, 64'h0000_0000_7FFF_FFFF);
        check("train_err",  err_v,  64'd0);

        arm_pulse();
        run_capture(40, -1, 5, SEL_DELAY, 16'd0, -1, -1);
        check("lock_err", err_v, 64'h20);
        check("lock_out", out_v, TRAIN_OUT);

        arm_pulse();
        run_capture(40, -1, -1, SEL_DELAY, 16'd0, -1, -1);
        check("lock_rerun_out", out_v, TRAIN_OUT);

        arm_pulse();
        run_capture(40, 21, -1, SEL_DELAY, 16'd0, -1, -1);
        check("abort_out",  out_v,  64'h0000_0000_0011_E000);
        check("abort_done", done_v, 64'd0);
        check("abort_busy", busy_v, 64'h0000_0000_001F_FFFF);

        run_capture(40, -1, -1, SEL_DELAY, 16'd0, -1, -1);
        check("unarmed_out",  out_v,  64'd0);
        check("unarmed_busy", busy_v, 64'd0);

        cfg_write(SEL_COUNT, 16'd1);
        arm_pulse();
        run_capture(40, -1, -1, SEL_DELAY, 16'd0, 5, 7);
        check("retrig_out",  out_v,  64'h0000_0000_0001_E000);
        check("retrig_done", done_v, 64'h0000_0000_0004_0000);

        cfg_write(SEL_DELAY, 16'd0);
        cfg_write(SEL_WIDTH, 16'd8);
        arm_pulse();
        trigger = 1'b1;
        repeat (5) tick();
        check("rst_mid_pulse_high", 64'(glitch_out), 64'd1);
        #2 glitch_reset = 1'b1;
        #1;
        check("rst_async_out",  64'(glitch_out), 64'd0);
        check("rst_async_busy", 64'(busy),       64'd0);
        #2 glitch_reset = 1'b0;
        trigger = 1'b0;
        repeat (5) tick();

        run_capture(40, -1, -1, SEL_DELAY, 16'd0, -1, -1);
        check("post_rst_disarmed", out_v, 64'd0);

        arm_pulse();
        run_capture(40, -1, -1, SEL_DELAY, 16'd0, -1, -1);
        check("post_rst_dflt_out",  out_v,  64'h8);
        check("post_rst_dflt_done", done_v, 64'h20);

        cfg_write(SEL_COUNT, 16'd2);
        arm_pulse();
        run_capture(40, -1, -1, SEL_DELAY, 16'd0, -1, -1);
        check("post_rst_gap_out",  out_v,  64'h28);
        check("post_rst_gap_done", done_v, 64'h80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
